// File: rtl/dispatch_pkg.sv
// Shared opcode constants, operand-usage helpers and the issue status encoding
// for the dispatch/issue controller.
package dispatch_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2,
    FLUSH  = 2'd3
  } status_t;

  // A stage produces a register result only for these opcodes, and x0 is never a real target.
  function automatic logic writes_rd(input logic [6:0] opcode, input logic [4:0] dest);
    logic wr;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_OP, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: wr = 1'b1;
      default:                      wr = 1'b0;
    endcase
    return wr && (dest != 5'd0);
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/dispatch_issue_control_if.sv
// Fetch-side enqueue and decode-side issue handshakes of the dispatch controller.
interface dispatch_issue_control_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  enq_valid;
  logic [DATA_WIDTH-1:0] enq_instruction;
  logic                  enq_ready;
  logic                  issue_valid;
  logic [DATA_WIDTH-1:0] issue_instruction;
  logic                  issue_ready;

  modport master (
    output enq_valid, enq_instruction, issue_ready,
    input  enq_ready, issue_valid, issue_instruction
  );

  modport slave (
    input  enq_valid, enq_instruction, issue_ready,
    output enq_ready, issue_valid, issue_instruction
  );
endinterface

// File: rtl/dispatch_queue.sv
// Circular instruction buffer: head/tail pointers wrap modulo depth, count is one bit wider.
module dispatch_queue #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_WIDTH-1:0]  push_data,
  output logic [DATA_WIDTH-1:0]  head_data,
  output logic [INDEX_WIDTH:0]   count
);
  localparam int DEPTH = 2 ** INDEX_WIDTH;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [INDEX_WIDTH-1:0] head;
  logic [INDEX_WIDTH-1:0] tail;

  // Pointer and occupancy bookkeeping; flush empties the queue without touching storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + (INDEX_WIDTH+1)'(push) - (INDEX_WIDTH+1)'(pop);
    end
  end

  // Entry storage is never cleared; stale words are unreachable once count is zero.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[tail] <= push_data;
  end

  assign head_data = (count != '0) ? mem[head] : '0;

endmodule

// File: rtl/dispatch_issue_control.sv
// Issue controller between fetch and decode: queues instructions and releases the
// head only when none of its sources is a pending destination in ID, EXE or MEM.
module dispatch_issue_control
  import dispatch_pkg::*;
#(
  parameter int CORE        = 0,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  dispatch_issue_control_if.slave   bus,
  input  logic [6:0]                id_opcode,
  input  logic [6:0]                exe_opcode,
  input  logic [6:0]                mem_opcode,
  input  logic [4:0]                id_dest,
  input  logic [4:0]                exe_dest,
  input  logic [4:0]                mem_dest,
  output logic [1:0]                status,
  output logic [15:0]               stall_count,
  output logic [31:0]               issue_count
);
  localparam int DEPTH = 2 ** INDEX_WIDTH;

  logic [INDEX_WIDTH:0]  count;
  logic [INDEX_WIDTH:0]  count_next;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  full;
  logic                  nonempty;
  logic                  push;
  logic                  pop;
  logic [6:0]            head_opcode;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic                  hit_rs1;
  logic                  hit_rs2;
  logic                  hazard;
  status_t               state;
  status_t               state_next;

  dispatch_queue #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (bus.enq_instruction),
    .head_data (head_data),
    .count     (count)
  );

  assign full     = (count == (INDEX_WIDTH+1)'(DEPTH));
  assign nonempty = (count != '0);

  assign head_opcode = head_data[6:0];
  assign rs1         = head_data[19:15];
  assign rs2         = head_data[24:20];

  // WB is left out: the register file writes before it is read in the same cycle.
  assign hit_rs1 = (writes_rd(id_opcode,  id_dest)  && (rs1 == id_dest))  ||
                   (writes_rd(exe_opcode, exe_dest) && (rs1 == exe_dest)) ||
                   (writes_rd(mem_opcode, mem_dest) && (rs1 == mem_dest));
  assign hit_rs2 = (writes_rd(id_opcode,  id_dest)  && (rs2 == id_dest))  ||
                   (writes_rd(exe_opcode, exe_dest) && (rs2 == exe_dest)) ||
                   (writes_rd(mem_opcode, mem_dest) && (rs2 == mem_dest));
  assign hazard  = nonempty && ((uses_rs1(head_opcode) && hit_rs1) ||
                                (uses_rs2(head_opcode) && hit_rs2));

  assign bus.enq_ready         = !full && !flush;
  assign bus.issue_valid       = nonempty && !hazard && !flush;
  assign bus.issue_instruction = head_data;

  assign push = bus.enq_valid && bus.enq_ready;
  assign pop  = bus.issue_valid && bus.issue_ready;

  assign count_next = flush ? '0 : count + (INDEX_WIDTH+1)'(push) - (INDEX_WIDTH+1)'(pop);

  // Status register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Next status from the occupancy after this edge and the current head's hazard.
  always_comb begin
    state_next = state;
    if (flush)                  state_next = FLUSH;
    else if (count_next == '0)  state_next = EMPTY;
    else if (hazard)            state_next = STALL;
    else                        state_next = ACTIVE;
  end

  // Statistics survive a flush; only reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      issue_count <= '0;
    end else begin
      if ((state_next == STALL) && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
      if (pop) issue_count <= issue_count + 32'd1;
    end
  end

  assign status = state;

endmodule

// File: tb/tb_dispatch_issue_control.sv
// Randomised and directed bench for dispatch_issue_control with a queue-based reference model.
module tb_dispatch_issue_control;

  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_OP_IMM = 7'b0010011;
  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [6:0]  id_opcode = '0, exe_opcode = '0, mem_opcode = '0;
  logic [4:0]  id_dest = '0, exe_dest = '0, mem_dest = '0;
  logic [1:0]  status;
  logic [15:0] stall_count;
  logic [31:0] issue_count;

  dispatch_issue_control_if #(.DATA_WIDTH(32)) bus ();

  dispatch_issue_control #(.CORE(0), .DATA_WIDTH(32), .INDEX_WIDTH(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .bus         (bus),
    .id_opcode   (id_opcode),
    .exe_opcode  (exe_opcode),
    .mem_opcode  (mem_opcode),
    .id_dest     (id_dest),
    .exe_dest    (exe_dest),
    .mem_dest    (mem_dest),
    .status      (status),
    .stall_count (stall_count),
    .issue_count (issue_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a set of registers pending in ID/EXE/MEM, tested against the head's sources.
  function automatic bit result_op(input logic [6:0] op);
    return op inside {T_LOAD, T_OP_IMM, T_OP, T_LUI, T_AUIPC, T_JAL, T_JALR};
  endfunction

  function automatic bit raw_hazard(input logic [31:0] ins);
    bit [31:0] pending;
    bit        hz;
    logic [6:0] op;
    pending = '0;
    if (result_op(id_opcode))  pending[id_dest]  = 1'b1;
    if (result_op(exe_opcode)) pending[exe_dest] = 1'b1;
    if (result_op(mem_opcode)) pending[mem_dest] = 1'b1;
    pending[0] = 1'b0;
    op = ins[6:0];
    hz = 1'b0;
    if (!(op inside {T_LUI, T_AUIPC, T_JAL}) && pending[ins[19:15]]) hz = 1'b1;
    if ((op inside {T_OP, T_STORE, T_BRANCH}) && pending[ins[24:20]]) hz = 1'b1;
    return hz;
  endfunction

  logic [31:0] mq[$];
  int          m_status = 0;
  int          m_stall  = 0;
  logic [31:0] m_issue  = '0;

  // Monitor/scoreboard: compare outputs away from the active edge, then advance the model.
  always @(negedge clock) begin
    int          n;
    bit          hz, e_rdy, e_iv;
    logic [31:0] exp_word;
    if (reset) begin
      mq.delete();
      m_status = 0;
      m_stall  = 0;
      m_issue  = '0;
      chk("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
      chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
      chk("rst_issue_instruction", bus.issue_instruction, 32'd0);
      chk("rst_status", 32'(status), 32'd0);
      chk("rst_stall_count", 32'(stall_count), 32'd0);
      chk("rst_issue_count", issue_count, 32'd0);
    end else begin
      n     = mq.size();
      hz    = (n != 0) && raw_hazard(mq[0]);
      e_rdy = (n < 8) && !flush;
      e_iv  = (n != 0) && !hz && !flush;
      chk("status", 32'(status), 32'(m_status));
      chk("stall_count", 32'(stall_count), 32'(m_stall));
      chk("issue_count", issue_count, m_issue);
      chk("enq_ready", 32'(bus.enq_ready), 32'(e_rdy));
      chk("issue_valid", 32'(bus.issue_valid), 32'(e_iv));
      if (n == 0) chk("issue_instruction_empty", bus.issue_instruction, 32'd0);
      if (flush) begin
        mq.delete();
        m_status = 3;
      end else begin
        if (e_iv && bus.issue_ready) begin
          exp_word = mq.pop_front();
          chk("issued_word", bus.issue_instruction, exp_word);
          m_issue = m_issue + 32'd1;
        end
        if (bus.enq_valid && e_rdy) mq.push_back(bus.enq_instruction);
        if (mq.size() == 0) m_status = 0;
        else if (hz)        m_status = 2;
        else                m_status = 1;
        if (m_status == 2 && m_stall < 65535) m_stall++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_stages();
    id_opcode = '0; exe_opcode = '0; mem_opcode = '0;
    id_dest = '0;   exe_dest = '0;   mem_dest = '0;
  endtask

  function automatic logic [31:0] tagged_add(input int tag);
    return {7'(tag), 5'd3, 5'd4, 3'b000, 5'd9, T_OP};
  endfunction

  logic [6:0] op_tab [9] = '{T_LOAD, T_OP_IMM, T_OP, T_LUI, T_AUIPC, T_JAL, T_JALR, T_STORE, T_BRANCH};

  initial begin
    logic [31:0] ins;
    bus.enq_valid = 1'b0;
    bus.enq_instruction = '0;
    bus.issue_ready = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Fill the queue with independent ADDs; the ninth offer must be refused.
    for (int i = 0; i < 9; i++) begin
      bus.enq_valid = 1'b1;
      bus.enq_instruction = tagged_add(i + 1);
      step();
    end
    bus.enq_valid = 1'b0;
    bus.issue_ready = 1'b1;
    repeat (10) step();
    bus.issue_ready = 1'b0;
    step();

    // RAW on rs2 against EXE for three cycles, then release.
    bus.enq_valid = 1'b1;
    bus.enq_instruction = 32'h0020_8033;
    bus.issue_ready = 1'b1;
    step();
    bus.enq_valid = 1'b0;
    exe_opcode = T_OP;
    exe_dest = 5'd2;
    repeat (3) step();
    exe_dest = 5'd0;
    repeat (2) step();
    clear_stages();

    // Source x5 against a STORE dest=5 and writers to x0: no hazard.
    bus.enq_valid = 1'b1;
    bus.enq_instruction = {7'd0, 5'd0, 5'd5, 3'b000, 5'd6, T_OP};
    id_opcode = T_STORE;  id_dest = 5'd5;
    exe_opcode = T_OP;    exe_dest = 5'd0;
    mem_opcode = T_LOAD;  mem_dest = 5'd0;
    step();
    bus.enq_valid = 1'b0;
    repeat (2) step();
    clear_stages();

    // Full queue with simultaneous enqueue and issue, then wrap the pointers.
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.enq_valid = 1'b1;
      bus.enq_instruction = tagged_add(16 + i);
      step();
    end
    bus.enq_instruction = tagged_add(40);
    bus.issue_ready = 1'b1;
    step();
    bus.issue_ready = 1'b0;
    bus.enq_instruction = tagged_add(41);
    step();
    bus.enq_valid = 1'b0;
    bus.issue_ready = 1'b1;
    repeat (4) step();
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.enq_valid = 1'b1;
      bus.enq_instruction = tagged_add(42 + i);
      step();
    end
    bus.enq_valid = 1'b0;
    bus.issue_ready = 1'b1;
    repeat (10) step();

    // Flush with five queued and an enqueue offered the same cycle.
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.enq_valid = 1'b1;
      bus.enq_instruction = tagged_add(50 + i);
      step();
    end
    flush = 1'b1;
    bus.enq_instruction = tagged_add(60);
    step();
    flush = 1'b0;
    bus.enq_valid = 1'b0;
    bus.issue_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset while stalled.
    bus.enq_valid = 1'b1;
    bus.enq_instruction = 32'h0020_8033;
    step();
    bus.enq_valid = 1'b0;
    mem_opcode = T_LOAD;
    mem_dest = 5'd1;
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    chk("async_enq_ready", 32'(bus.enq_ready), 32'd1);
    chk("async_issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("async_issue_instruction", bus.issue_instruction, 32'd0);
    chk("async_status", 32'(status), 32'd0);
    chk("async_stall_count", 32'(stall_count), 32'd0);
    chk("async_issue_count", issue_count, 32'd0);
    step();
    reset = 1'b0;
    clear_stages();
    step();

    // Random traffic over a small register range so hazards are frequent.
    for (int c = 0; c < 600; c++) begin
      ins = $urandom;
      ins[6:0]   = op_tab[$urandom_range(0, 8)];
      ins[19:15] = 5'($urandom_range(0, 4));
      ins[24:20] = 5'($urandom_range(0, 4));
      bus.enq_valid = 1'($urandom_range(0, 1));
      bus.enq_instruction = ins;
      bus.issue_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 29) == 0);
      id_opcode  = op_tab[$urandom_range(0, 8)];
      exe_opcode = op_tab[$urandom_range(0, 8)];
      mem_opcode = op_tab[$urandom_range(0, 8)];
      id_dest  = 5'($urandom_range(0, 4));
      exe_dest = 5'($urandom_range(0, 4));
      mem_dest = 5'($urandom_range(0, 4));
      step();
    end

    bus.enq_valid = 1'b0;
    flush = 1'b0;
    clear_stages();
    bus.issue_ready = 1'b1;
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
